// File: rtl/rr_seq_pkg.sv
// Shared types and constants for the round-robin channel sequencer.
package rr_seq_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate req so the channel after ptr sits at
// bit 0, then take the lowest set bit and map it back to a channel index.
module rr_priority_pick
  import rr_seq_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [2:0]        shift;
  logic [SEL_W-1:0]  off;

  always_comb begin
    dbl   = {req, req};
    shift = {1'b0, ptr} + 3'd1;
    rot   = dbl[shift +: N_CH];
    off   = '0;
    // Scan from the top so the lowest set bit is the one left in off.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    winner = ptr + off + 2'd1;
    any    = |req;
  end

endmodule

// File: rtl/rr_channel_sequencer.sv
// Round-robin grant sequencer driving a 2-to-4 decoder with a one-cycle dead gap
// between grants. The consumer release pulse is named rel since release is a keyword.
module rr_channel_sequencer
  import rr_seq_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             rel,
  output logic [SEL_W-1:0] sel,
  output logic             sel_en,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, winner;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sel_en_n, busy_n, timeout_n, any;
  logic             expired, withdrawn;

  rr_priority_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      sel     <= '0;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      sel_en  <= sel_en_n;
      busy    <= busy_n;
      timeout <= timeout_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    sel_en_n  = sel_en;
    busy_n    = busy;
    timeout_n = 1'b0;
    cnt_n     = cnt;
    expired   = (cnt == HOLD_LIM);
    withdrawn = ~req[sel];

    case (state)
      IDLE, GAP: begin
        if (any) begin
          state_n  = GRANT;
          sel_n    = winner;
          ptr_n    = winner;
          sel_en_n = 1'b1;
          busy_n   = 1'b1;
          cnt_n    = CNT_W'(1);
        end else begin
          state_n  = IDLE;
          sel_en_n = 1'b0;
          busy_n   = 1'b0;
          cnt_n    = '0;
        end
      end
      GRANT: begin
        // Release or withdrawal on the expiry edge wins, so no timeout pulse then.
        if (rel || withdrawn || expired) begin
          state_n   = GAP;
          sel_en_n  = 1'b0;
          busy_n    = 1'b1;
          cnt_n     = '0;
          timeout_n = expired && !rel && !withdrawn;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        sel_en_n = 1'b0;
        busy_n   = 1'b0;
        cnt_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_channel_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized run compared against a behavioural round-robin model.
module tb_rr_channel_sequencer;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [1:0] sel;
  logic       sel_en;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int passed = 0;

  // Behavioural model: mode 0 = idle, 1 = granting, 2 = dead gap.
  int m_mode, m_sel, m_last, m_hold;
  bit m_en, m_busy, m_to;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[19];

  rr_channel_sequencer #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .sel     (sel),
    .sel_en  (sel_en),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_last = 3; m_hold = 0;
    m_en = 0; m_busy = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rl);
    m_to = 0;
    if (m_mode == 1) begin
      if (rl || !r[m_sel] || m_hold == MAX_HOLD) begin
        m_to   = !rl && r[m_sel];
        m_mode = 2;
        m_en   = 0;
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end else if (r != 4'b0000) begin
      m_sel  = pick(r, m_last);
      m_last = m_sel;
      m_mode = 1;
      m_en   = 1;
      m_busy = 1;
      m_hold = 1;
    end else begin
      m_mode = 0;
      m_en   = 0;
      m_busy = 0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    model_step(r, rl);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] es,
                             input logic ee, input logic eb, input logic et);
    checks++;
    if ({sel, sel_en, busy, timeout} === {es, ee, eb, et}) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got sel=%0d en=%b busy=%b to=%b, expected sel=%0d en=%b busy=%b to=%b",
               name, sel, sel_en, busy, timeout, es, ee, eb, et);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_state", 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Rotation from reset, release ignored in idle, then single-requester grants.
    vecs[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    doReset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].req, vecs[i].rel);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].en, vecs[i].busy, vecs[i].to);
    end

    // Hold timer expiry with no release, then release landing on the expiry edge.
    doReset();
    for (int k = 0; k < MAX_HOLD; k++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("hold_cycle%0d", k), 2'd2, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0100, 1'b0);
    checkOutput("timeout_exit", 2'd2, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("timeout_regrant", 2'd2, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < MAX_HOLD; k++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("hold2_cycle%0d", k), 2'd2, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0100, 1'b1);
    checkOutput("release_at_expiry", 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("back_to_idle", 2'd2, 1'b0, 1'b0, 1'b0);

    // Withdrawal of the granted channel, then pointer-relative re-arbitration.
    doReset();
    applyStimulus(4'b0010, 1'b0);
    checkOutput("grant_ch1", 2'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("grant_ch1_hold", 2'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("withdraw_gap", 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("rearb_ch3", 2'd3, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while a grant is active.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    req   = 4'b1000;
    rst_n = 1'b1;
    applyStimulus(4'b1000, 1'b0);
    checkOutput("post_reset_grant", 2'd3, 1'b1, 1'b1, 1'b0);

    // Randomized traffic against the model; requests change in bursts.
    doReset();
    begin
      logic [3:0] r;
      logic       rl;
      r = 4'b0000;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        rl = ($urandom_range(0, 4) == 0);
        applyStimulus(r, rl);
        checkOutput($sformatf("rand%0d", n), 2'(m_sel), m_en, m_busy, m_to);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
